// File: rtl/snek_ctrl.sv
// snek_ctrl: game controller that runs ahead of the snake body generator.
// It runs the SPLASH/PLAY/OVER state machine and latches the player direction.
// It also places food from a 16-bit LFSR, detects eating, pulses grow_flag,
// keeps the score, drives run and pulses snek_rst when the game restarts.
// Optional build macro: SNEK_SPEED_STEP_EN. When it is defined, run pulses
// once every max(STEP_MIN, STEP_DIV - score/4) frames instead of being a level.
module snek_ctrl #(
  parameter int          MAXLEN    = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          STEP_DIV  = 8,
  parameter int          STEP_MIN  = 2
) (
  input  logic       frame_clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_up,
  input  logic [5:0] head_h,
  input  logic [5:0] head_v,
  input  logic [7:0] body_counter,
  input  logic       dead,
  output logic [2:0] dir,
  output logic       grow_flag,
  output logic       run,
  output logic       snek_rst,
  output logic [5:0] food_h,
  output logic [5:0] food_v,
  output logic [7:0] score,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    ST_SPLASH = 2'd0,
    ST_PLAY   = 2'd1,
    ST_OVER   = 2'd2
  } state_e;

  localparam logic [2:0] DIR_HOLD = 3'd4;

  state_e      state_q, state_d;
  logic [2:0]  dir_q, dir_d;
  logic        grow_q, grow_d;
  logic        run_q, run_d;
  logic        snek_rst_q, snek_rst_d;
  logic [5:0]  food_h_q, food_h_d;
  logic [5:0]  food_v_q, food_v_d;
  logic [7:0]  score_q, score_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        start_q, start_d;

  logic        start_rise;
  logic        eat;
  logic        btn_any;
  logic [2:0]  btn_dir;
  logic [4:0]  raw_v;
  logic [5:0]  cand_h;
  logic [5:0]  cand_v;

`ifdef SNEK_SPEED_STEP_EN
  logic [7:0]  step_q, step_d;
  logic [7:0]  step_n;
`endif

  assign start_rise = btn_start & ~start_q;
  assign eat        = (head_h == food_h_q) & (head_v == food_v_q) & ~dead;

  // Register every piece of state; rst restores the power-on values
  always_ff @(posedge frame_clk) begin
    if (rst) begin
      state_q    <= ST_SPLASH;
      dir_q      <= DIR_HOLD;
      grow_q     <= 1'b0;
      run_q      <= 1'b0;
      snek_rst_q <= 1'b0;
      food_h_q   <= 6'd5;
      food_v_q   <= 6'd5;
      score_q    <= 8'd0;
      lfsr_q     <= LFSR_SEED;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      grow_q     <= grow_d;
      run_q      <= run_d;
      snek_rst_q <= snek_rst_d;
      food_h_q   <= food_h_d;
      food_v_q   <= food_v_d;
      score_q    <= score_d;
      lfsr_q     <= lfsr_d;
      start_q    <= start_d;
    end
  end

  // Next game state from the start edge and the generator's dead flag
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SPLASH: begin
        if (start_rise) state_d = ST_PLAY;
        else            state_d = ST_SPLASH;
      end
      ST_PLAY: begin
        if (dead) state_d = ST_OVER;
        else      state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_SPLASH;
        else            state_d = ST_OVER;
      end
      default: state_d = ST_SPLASH;
    endcase
  end

  // Free-running LFSR and the food candidate derived from it
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    start_d = btn_start;
    raw_v   = lfsr_q[12:8];
    cand_h  = {1'b0, lfsr_q[4:0]};
    if (raw_v < 5'd24) cand_v = {1'b0, raw_v};
    else               cand_v = {1'b0, raw_v - 5'd8};
    // Never drop food directly on the head; nudge one column right instead
    if ((cand_h == head_h) && (cand_v == head_v)) cand_h = {1'b0, cand_h[4:0] + 5'd1};
    else                                          cand_h = cand_h;
  end

  // Pick one direction button with priority left > right > down > up
  always_comb begin
    btn_any = 1'b1;
    btn_dir = DIR_HOLD;
    if      (btn_left)  btn_dir = 3'd0;
    else if (btn_right) btn_dir = 3'd1;
    else if (btn_down)  btn_dir = 3'd2;
    else if (btn_up)    btn_dir = 3'd3;
    else                btn_any = 1'b0;
  end

`ifdef SNEK_SPEED_STEP_EN
  // Frames per step shrink by one every four apples, floored at STEP_MIN
  always_comb begin
    if (({2'b00, score_q[7:2]} + 8'(STEP_MIN)) >= 8'(STEP_DIV)) step_n = 8'(STEP_MIN);
    else                                                         step_n = 8'(STEP_DIV) - {2'b00, score_q[7:2]};
  end

  // Step counter: restarts on PLAY entry and after each step pulse
  always_ff @(posedge frame_clk) begin
    if (rst) step_q <= 8'd0;
    else     step_q <= step_d;
  end
`endif

  // Registered outputs: direction, food, score, grow, run and snek_rst
  always_comb begin
    dir_d      = dir_q;
    grow_d     = 1'b0;
    snek_rst_d = 1'b0;
    food_h_d   = food_h_q;
    food_v_d   = food_v_q;
    score_d    = score_q;
    case (state_q)
      ST_SPLASH: begin
        dir_d = DIR_HOLD;
        if (start_rise) begin
          score_d  = 8'd0;
          food_h_d = cand_h;
          food_v_d = cand_v;
        end else begin
          score_d = score_q;
        end
      end
      ST_PLAY: begin
        if (dead) begin
          dir_d = DIR_HOLD;
        end else begin
          // Reject an exact reversal; dir=4 never matches since bit 2 is set
          if (btn_any && (dir_q != {1'b0, btn_dir[1], ~btn_dir[0]})) dir_d = btn_dir;
          else                                                        dir_d = dir_q;
          if (eat) begin
            if (score_q != 8'd255) score_d = score_q + 8'd1;
            else                   score_d = score_q;
            food_h_d = cand_h;
            food_v_d = cand_v;
            grow_d   = (body_counter < 8'(MAXLEN));
          end else begin
            grow_d = 1'b0;
          end
        end
      end
      ST_OVER: begin
        dir_d      = DIR_HOLD;
        snek_rst_d = start_rise;
      end
      default: begin
        dir_d = DIR_HOLD;
      end
    endcase
  end

`ifdef SNEK_SPEED_STEP_EN
  // Gated run: one pulse every step_n frames while staying in PLAY
  always_comb begin
    run_d  = 1'b0;
    step_d = 8'd0;
    if ((state_q == ST_PLAY) && (state_d == ST_PLAY)) begin
      if (step_q >= (step_n - 8'd1)) begin
        run_d  = 1'b1;
        step_d = 8'd0;
      end else begin
        step_d = step_q + 8'd1;
      end
    end else begin
      step_d = 8'd0;
    end
  end
`else
  // Ungated run: a level that follows the PLAY state
  always_comb begin
    run_d = (state_d == ST_PLAY);
  end
`endif

  assign dir        = dir_q;
  assign grow_flag  = grow_q;
  assign run        = run_q;
  assign snek_rst   = snek_rst_q;
  assign food_h     = food_h_q;
  assign food_v     = food_v_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_snek_ctrl.sv
// Directed bench for snek_ctrl with hand-derived expected values.
// A small LFSR and food-candidate model provides the expected food positions.
module tb_snek_ctrl;

  logic       frame_clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_up = 1'b0;
  logic [5:0] head_h = 6'd63, head_v = 6'd63;
  logic [7:0] body_counter = 8'd3;
  logic       dead = 1'b0;
  logic [2:0] dir;
  logic       grow_flag, run, snek_rst;
  logic [5:0] food_h, food_v;
  logic [7:0] score;
  logic [1:0] game_state;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;
  logic [5:0]  exp_fh, exp_fv;
  logic [7:0]  exp_score;
  logic [11:0] nxt;
  int          run_cnt;

  snek_ctrl dut (
    .frame_clk(frame_clk), .rst(rst), .btn_start(btn_start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_up(btn_up),
    .head_h(head_h), .head_v(head_v), .body_counter(body_counter), .dead(dead),
    .dir(dir), .grow_flag(grow_flag), .run(run), .snek_rst(snek_rst),
    .food_h(food_h), .food_v(food_v), .score(score), .game_state(game_state)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference LFSR stepped alongside the design
  always @(posedge frame_clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Food candidate {h, v} for a given LFSR value and head position
  function automatic logic [11:0] cand(input logic [15:0] l, input logic [5:0] hh, input logic [5:0] hv);
    logic [5:0] h, v;
    h = {1'b0, l[4:0]};
    v = {1'b0, l[12:8]};
    if (v >= 6'd24) v = v - 6'd8;
    if (h == hh && v == hv) h = (h + 6'd1) & 6'd31;
    return {h, v};
  endfunction

  task automatic set_btn(input logic l, input logic r, input logic d, input logic u);
    btn_left = l; btn_right = r; btn_down = d; btn_up = u;
  endtask

  // Put the head on the expected food and advance one eating frame
  task automatic eat_once();
    head_h = exp_fh; head_v = exp_fv;
    nxt = cand(m_lfsr, exp_fh, exp_fv);
    tick();
    exp_fh = nxt[11:6]; exp_fv = nxt[5:0];
    if (exp_score != 8'd255) exp_score = exp_score + 8'd1;
  endtask

  initial begin
    exp_score = 8'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_state", 16'(game_state), 16'd0);
    check("rst_dir",   16'(dir),        16'd4);
    check("rst_run",   16'(run),        16'd0);
    check("rst_grow",  16'(grow_flag),  16'd0);
    check("rst_snrst", 16'(snek_rst),   16'd0);
    check("rst_food",  {4'd0, food_h, food_v}, {4'd0, 6'd5, 6'd5});
    check("rst_score", 16'(score),      16'd0);

    // Start held three frames: one transition, food from LFSR at that edge
    btn_start = 1'b1;
    nxt = cand(m_lfsr, head_h, head_v);
    tick();
    exp_fh = nxt[11:6]; exp_fv = nxt[5:0];
    check("start_state", 16'(game_state), 16'd1);
    check("start_score", 16'(score), 16'd0);
    check("start_dir",   16'(dir), 16'd4);
    check("start_food",  {4'd0, food_h, food_v}, {4'd0, exp_fh, exp_fv});
    run_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (run) run_cnt++;
      check("start_hold", 16'(game_state), 16'd1);
    end
    btn_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (run) run_cnt++;
    end
`ifdef SNEK_SPEED_STEP_EN
    check("run_pulses_n8", 16'(run_cnt), 16'd2);
`else
    check("run_level", 16'(run_cnt), 16'd16);
`endif

    // Direction handling
    set_btn(1'b0, 1'b1, 1'b0, 1'b0); tick(); check("dir_right", 16'(dir), 16'd1);
    set_btn(1'b1, 1'b0, 1'b0, 1'b0); tick(); check("dir_rev_l", 16'(dir), 16'd1);
    set_btn(1'b0, 1'b0, 1'b1, 1'b0); tick(); check("dir_down",  16'(dir), 16'd2);
    set_btn(1'b1, 1'b0, 1'b0, 1'b0); tick(); check("dir_left",  16'(dir), 16'd0);
    set_btn(1'b0, 1'b0, 1'b1, 1'b0); tick(); check("dir_down2", 16'(dir), 16'd2);
    set_btn(1'b1, 1'b0, 1'b0, 1'b1); tick(); check("dir_prio",  16'(dir), 16'd0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b1); tick(); check("dir_up",    16'(dir), 16'd3);
    set_btn(1'b0, 1'b0, 1'b1, 1'b0); tick(); check("dir_rev_d", 16'(dir), 16'd3);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0); tick(); check("dir_hold",  16'(dir), 16'd3);

    // Eat with room to grow
    body_counter = 8'd3;
    eat_once();
    check("eat_grow",  16'(grow_flag), 16'd1);
    check("eat_score", 16'(score), 16'(exp_score));
    check("eat_food",  {4'd0, food_h, food_v}, {4'd0, exp_fh, exp_fv});
    check("food_off_head", 16'({food_h, food_v} != {head_h, head_v}), 16'd1);
    head_h = 6'd63; head_v = 6'd63;
    tick();
    check("grow_one_cyc", 16'(grow_flag), 16'd0);

    // Eat at capacity: score moves, no grow
    body_counter = 8'd16;
    eat_once();
    check("cap_grow",  16'(grow_flag), 16'd0);
    check("cap_score", 16'(score), 16'd2);

    // Saturate the score
    for (int i = 0; i < 253; i++) eat_once();
    check("score_255", 16'(score), 16'd255);
    eat_once();
    check("score_sat", 16'(score), 16'd255);
    check("sat_food",  {4'd0, food_h, food_v}, {4'd0, exp_fh, exp_fv});
    head_h = 6'd63; head_v = 6'd63;
    tick();

    // Dead together with eat: dead wins
    head_h = exp_fh; head_v = exp_fv; dead = 1'b1;
    tick();
    dead = 1'b0; head_h = 6'd63; head_v = 6'd63;
    check("dead_state", 16'(game_state), 16'd2);
    check("dead_score", 16'(score), 16'd255);
    check("dead_grow",  16'(grow_flag), 16'd0);
    check("dead_run",   16'(run), 16'd0);
    check("dead_dir",   16'(dir), 16'd4);
    check("dead_food",  {4'd0, food_h, food_v}, {4'd0, exp_fh, exp_fv});

    // Over: direction ignored, then restart pulses snek_rst once
    set_btn(1'b0, 1'b1, 1'b0, 1'b0); tick(); set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    check("over_dir",   16'(dir), 16'd4);
    check("over_stay",  16'(game_state), 16'd2);
    btn_start = 1'b1;
    tick();
    check("restart_state", 16'(game_state), 16'd0);
    check("restart_snrst", 16'(snek_rst), 16'd1);
    tick();
    check("snrst_one_cyc", 16'(snek_rst), 16'd0);
    check("no_retrigger",  16'(game_state), 16'd0);
    btn_start = 1'b0;
    tick();

    // New game, then reset mid-game
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
    check("replay_state", 16'(game_state), 16'd1);
    check("replay_score", 16'(score), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_state", 16'(game_state), 16'd0);
    check("mrst_score", 16'(score), 16'd0);
    check("mrst_food",  {4'd0, food_h, food_v}, {4'd0, 6'd5, 6'd5});
    check("mrst_snrst", 16'(snek_rst), 16'd0);
    check("mrst_run",   16'(run), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
